// File: rtl/huffman_pkg.sv
// Constants, loader FSM states and error codes shared by the Huffman encoder,
// decoder and codebook loader.
package huffman_pkg;

  localparam int SYM_W        = 8;
  localparam int CODE_W       = 16;
  localparam int LEN_W        = 5;
  localparam int MAX_CODE_LEN = 16;
  localparam int NUM_SYMBOLS  = 256;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ENTRY,
    DRIVE,
    RELEASE,
    FINISH,
    ERR
  } loader_state_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_COUNT = 2'd1,
    ERR_LEN   = 2'd2,
    ERR_ACK   = 2'd3
  } err_code_e;

  typedef struct packed {
    logic [SYM_W-1:0]  symbol;
    logic [CODE_W-1:0] code;
    logic [LEN_W-1:0]  length;
  } cb_entry_t;

  function automatic logic len_ok(input logic [LEN_W-1:0] len);
    return (len != '0) && (len <= LEN_W'(MAX_CODE_LEN));
  endfunction

endpackage

// File: rtl/huffman_codebook_loader_if.sv
// Entry stream (valid/ready) plus decoder load bus (level valid / ack).
// master = the loader, slave = software source and decoder side.
interface huffman_codebook_loader_if;

  logic                             entry_valid;
  logic                             entry_ready;
  logic [huffman_pkg::SYM_W-1:0]    entry_symbol;
  logic [huffman_pkg::CODE_W-1:0]   entry_code;
  logic [huffman_pkg::LEN_W-1:0]    entry_length;

  logic [huffman_pkg::SYM_W-1:0]    dec_load_symbol;
  logic [huffman_pkg::CODE_W-1:0]   dec_load_code;
  logic [huffman_pkg::LEN_W-1:0]    dec_load_length;
  logic                             dec_load_valid;
  logic                             dec_load_ack;

  modport master (
    input  entry_valid, entry_symbol, entry_code, entry_length, dec_load_ack,
    output entry_ready, dec_load_symbol, dec_load_code, dec_load_length, dec_load_valid
  );

  modport slave (
    output entry_valid, entry_symbol, entry_code, entry_length, dec_load_ack,
    input  entry_ready, dec_load_symbol, dec_load_code, dec_load_length, dec_load_valid
  );

endinterface

// File: rtl/huffman_codebook_loader_ack.sv
// huffman_ack_timer: loadable down-counter; o_expire is high once the count reaches zero.
module huffman_ack_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic i_load,
  output logic o_expire
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] r_count;

  // Loading TIMEOUT-1 makes expire fire in the TIMEOUT-th cycle after the load edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= W'(TIMEOUT - 1);
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expire = (r_count == '0);

endmodule

// File: rtl/huffman_codebook_loader.sv
// Moves software codebook entries onto the decoder's edge-detected load handshake.
// Optional DUP_CHECK_EN: a seen-symbol bitmap rejects duplicate symbols and raises o_dup_error.
module huffman_codebook_loader
  import huffman_pkg::*;
#(
  parameter int MAX_ENTRIES = 256,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      i_start,
  input  logic                      i_abort,
  input  logic [8:0]                i_num_entries,
  huffman_codebook_loader_if.master bus,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_codebook_ready,
  output logic                      o_error,
  output logic [1:0]                o_error_code,
  output logic [8:0]                o_loaded_count
`ifdef DUP_CHECK_EN
  ,
  output logic                      o_dup_error
`endif
);

  loader_state_e r_state;
  err_code_e     r_error_code;
  cb_entry_t     r_dec;
  logic [8:0]    r_num;
  logic [8:0]    r_loaded;
  logic          r_busy, r_done, r_cb_ready, r_error;
  logic          r_entry_ready, r_dec_valid, r_abort_pending;

  logic w_idle_like, w_bad_count, w_len_ok, w_dup, w_accept;
  logic w_go_drive, w_go_release, w_timer_load, w_expire;

  assign w_idle_like  = (r_state == IDLE) || (r_state == FINISH) || (r_state == ERR);
  assign w_bad_count  = (i_num_entries == '0) || (32'(i_num_entries) > MAX_ENTRIES);
  assign w_len_ok     = len_ok(bus.entry_length);
  assign w_accept     = (r_state == WAIT_ENTRY) && !i_abort && bus.entry_valid && r_entry_ready;
  assign w_go_drive   = w_accept && w_len_ok && !w_dup;
  assign w_go_release = (r_state == DRIVE) && bus.dec_load_ack;
  assign w_timer_load = w_go_drive || w_go_release;

`ifdef DUP_CHECK_EN
  logic [NUM_SYMBOLS-1:0] r_seen;
  logic                   r_dup_flag;

  assign w_dup = r_seen[bus.entry_symbol];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_seen     <= '0;
      r_dup_flag <= 1'b0;
    end else if (w_idle_like && (i_start || i_abort)) begin
      r_seen     <= '0;
      r_dup_flag <= 1'b0;
    end else if (w_accept && w_len_ok) begin
      if (w_dup) r_dup_flag <= 1'b1;
      else       r_seen[bus.entry_symbol] <= 1'b1;
    end
  end

  assign o_dup_error = r_dup_flag;
`else
  assign w_dup = 1'b0;
`endif

  huffman_ack_timer #(
    .TIMEOUT (ACK_TIMEOUT)
  ) u_ack_timer (
    .clock    (clock),
    .reset    (reset),
    .i_load   (w_timer_load),
    .o_expire (w_expire)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state         <= IDLE;
      r_error_code    <= ERR_NONE;
      r_dec           <= '0;
      r_num           <= '0;
      r_loaded        <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_cb_ready      <= 1'b0;
      r_error         <= 1'b0;
      r_entry_ready   <= 1'b0;
      r_dec_valid     <= 1'b0;
      r_abort_pending <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE, FINISH, ERR: begin
          if (i_abort) begin
            r_state      <= IDLE;
            r_cb_ready   <= 1'b0;
            r_error      <= 1'b0;
            r_error_code <= ERR_NONE;
          end else if (i_start) begin
            r_loaded        <= '0;
            r_cb_ready      <= 1'b0;
            r_abort_pending <= 1'b0;
            if (w_bad_count) begin
              r_state      <= ERR;
              r_error      <= 1'b1;
              r_error_code <= ERR_COUNT;
            end else begin
              r_state       <= WAIT_ENTRY;
              r_num         <= i_num_entries;
              r_busy        <= 1'b1;
              r_entry_ready <= 1'b1;
              r_error       <= 1'b0;
              r_error_code  <= ERR_NONE;
            end
          end
        end
        WAIT_ENTRY: begin
          if (i_abort) begin
            r_state       <= IDLE;
            r_busy        <= 1'b0;
            r_entry_ready <= 1'b0;
          end else if (w_accept) begin
            r_entry_ready <= 1'b0;
            // Rejected entries are consumed but never reach the decoder.
            if (!w_len_ok || w_dup) begin
              r_state      <= ERR;
              r_busy       <= 1'b0;
              r_error      <= 1'b1;
              r_error_code <= w_len_ok ? ERR_ACK : ERR_LEN;
            end else begin
              r_dec       <= {bus.entry_symbol, bus.entry_code, bus.entry_length};
              r_dec_valid <= 1'b1;
              r_state     <= DRIVE;
            end
          end
        end
        DRIVE: begin
          if (i_abort) r_abort_pending <= 1'b1;
          if (bus.dec_load_ack) begin
            r_dec_valid <= 1'b0;
            r_state     <= RELEASE;
            if (r_loaded < r_num) r_loaded <= r_loaded + 9'd1;
          end else if (w_expire) begin
            r_dec_valid  <= 1'b0;
            r_state      <= ERR;
            r_busy       <= 1'b0;
            r_error      <= 1'b1;
            r_error_code <= ERR_ACK;
          end
        end
        RELEASE: begin
          // Ack must drop before the next entry so the decoder sees a fresh valid edge.
          if (!bus.dec_load_ack) begin
            r_abort_pending <= 1'b0;
            if (r_abort_pending || i_abort) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else if (r_loaded == r_num) begin
              r_state    <= FINISH;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_cb_ready <= 1'b1;
            end else begin
              r_state       <= WAIT_ENTRY;
              r_entry_ready <= 1'b1;
            end
          end else if (w_expire) begin
            r_state      <= ERR;
            r_busy       <= 1'b0;
            r_error      <= 1'b1;
            r_error_code <= ERR_ACK;
          end else if (i_abort) begin
            r_abort_pending <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.entry_ready     = r_entry_ready;
  assign bus.dec_load_symbol = r_dec.symbol;
  assign bus.dec_load_code   = r_dec.code;
  assign bus.dec_load_length = r_dec.length;
  assign bus.dec_load_valid  = r_dec_valid;
  assign o_busy              = r_busy;
  assign o_done              = r_done;
  assign o_codebook_ready    = r_cb_ready;
  assign o_error             = r_error;
  assign o_error_code        = r_error_code;
  assign o_loaded_count      = r_loaded;

endmodule

// File: doc/huffman_codebook_loader.md
Name: huffman_codebook_loader

Overview:
Sequences the Huffman decoder's codebook load port from a software-fed entry stream (valid/ready). Converts each accepted entry into the decoder's level-valid/acknowledge handshake, counts entries, and validates them. Asserts codebook_ready only after a full session loads cleanly; downstream logic gates decoding on codebook_ready. Sits between the AXI-lite/DMA software interface and the decoder.

Parameters:
MAX_ENTRIES, 256, upper bound on num_entries per session
ACK_TIMEOUT, 64, cycles allowed for each dec_load_ack edge before a timeout error

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; begins a load session using num_entries
abort  input  1  one-cycle pulse; cancels the session
num_entries  input  9  entries in the session, valid range 1..MAX_ENTRIES
entry_valid  input  1  entry stream valid
entry_ready  output  1  entry stream ready
entry_symbol  input  8  symbol index
entry_code  input  16  codeword, MSB-aligned
entry_length  input  5  code length
dec_load_symbol  output  8  to decoder load_symbol
dec_load_code  output  16  to decoder load_code
dec_load_length  output  5  to decoder load_length
dec_load_valid  output  1  to decoder load_valid (level)
dec_load_ack  input  1  from decoder load_valid_out
busy  output  1  session in progress
done  output  1  one-cycle pulse on successful completion
codebook_ready  output  1  level; table complete and consistent
error  output  1  sticky until next start or reset
error_code  output  2  0 none, 1 bad count, 2 bad length, 3 ack timeout or duplicate
loaded_count  output  9  entries acknowledged in the current session

Behaviour:
- Reset: state IDLE; all outputs 0, including the dec_load_* bus, entry_ready, and codebook_ready.
- FSM states: IDLE, WAIT_ENTRY, DRIVE, RELEASE, FINISH, ERR.
- IDLE/FINISH/ERR + start:
  - num_entries of 0 or above MAX_ENTRIES -> ERR with error_code 1.
  - Otherwise -> WAIT_ENTRY. Clear loaded_count, error, and codebook_ready; set busy.
- start while busy (WAIT_ENTRY/DRIVE/RELEASE) is ignored.
- WAIT_ENTRY:
  - entry_ready=1; an entry is accepted on entry_valid & entry_ready.
  - entry_length 0 or above 16 -> ERR with error_code 2. The entry is consumed but not driven.
  - Otherwise register the fields onto dec_load_* and go to DRIVE.
- DRIVE:
  - dec_load_valid=1 and entry_ready=0.
  - On dec_load_ack=1: increment loaded_count and go to RELEASE.
- RELEASE:
  - dec_load_valid=0.
  - Wait for dec_load_ack=0. The decoder edge-detects load_valid, so valid must be observed low before the next entry.
  - Then: if loaded_count equals num_entries (latched at start) -> FINISH; else -> WAIT_ENTRY.
- Timing:
  - Nominal per-entry cost is 4 cycles: accept, DRIVE, ack seen, RELEASE, ack low.
  - First dec_load_valid rises the cycle after acceptance.
- Timeout:
  - A cycle counter resets on entry to DRIVE and to RELEASE.
  - Reaching ACK_TIMEOUT in either state -> ERR with error_code 3 and dec_load_valid forced 0.
- FINISH: pulse done for one cycle; codebook_ready=1, busy=0. Hold until start.
- ERR: busy=0, error=1, codebook_ready=0, entry_ready=0. Hold until start.
- abort:
  - In IDLE/WAIT_ENTRY: go to IDLE immediately, codebook_ready=0.
  - In DRIVE/RELEASE: set abort_pending, complete the handshake through RELEASE, then go to IDLE. This never leaves the decoder mid-handshake.
  - In FINISH/ERR: go to IDLE, clearing codebook_ready and error.
- Simultaneous start and abort: abort wins.
- codebook_ready is 0 whenever busy=1.
- loaded_count saturates at num_entries and never wraps.

Optional Feature:
DUP_CHECK_EN
- Defined:
  - A 256-bit seen bitmap, cleared on start.
  - An accepted entry whose symbol is already marked -> ERR with error_code 3. Distinguish it from timeout via the internal dup_flag status bit, exposed as output dup_error.
- Not defined: duplicate symbols overwrite the earlier entry and count toward num_entries. The bitmap and dup_error are absent.

Decomposition:
- Package huffman_pkg holds:
  - constants SYM_W=8, CODE_W=16, LEN_W=5, MAX_CODE_LEN=16, NUM_SYMBOLS=256
  - loader state enum
  - error_code enum: ERR_NONE, ERR_COUNT, ERR_LEN, ERR_ACK
- Shared by the encoder, decoder, and this loader.
- One sub-module: huffman_ack_timer, a loadable down-counter with expire output, instantiated once.

Test Plan:
- start with num_entries=3; stream (0x41,0x0002,2), (0x42,0x0006,3), (0x43,0x0007,3); model acks one cycle after valid -> three valid pulses, each separated by valid-low, loaded_count=3, done pulse, codebook_ready=1, 12 cycles total.
- start with num_entries=0, and separately with num_entries=257 -> ERR, error_code=1, no dec_load_valid.
- Entry with length 0, then separately with length 17 -> ERR, error_code=2, loaded_count unchanged.
- Model never acks, ACK_TIMEOUT=64 -> ERR, error_code=3 exactly 64 cycles after DRIVE entry, dec_load_valid=0.
- abort during DRIVE with ack delayed 5 cycles -> handshake completes, then IDLE; codebook_ready=0; no further valid.
- DUP_CHECK_EN defined; symbol 0x10 sent twice -> ERR, dup_error=1. Not defined -> session completes with count 2.
